// File: rtl/approx_add_pkg.sv
// Package shared by the approximate-adder pipeline.
//  approx_add_ref : golden model of the lower-part-OR approximate adder (up to MAX_W bits)
//  seg_lo/seg_hi  : bit bounds of each pipeline segment of the exact upper part; low
//                   segments take the extra bit when the split is uneven
//  params_ok      : legality check of WIDTH / K / STAGES / accumulator width
package approx_add_pkg;

  localparam int MAX_W = 64;

  function automatic logic [MAX_W:0] approx_add_ref(input logic [MAX_W-1:0] a,
                                                    input logic [MAX_W-1:0] b,
                                                    input int width, input int k);
    logic [MAX_W:0]   r;
    logic [MAX_W:0]   hi;
    logic [MAX_W-1:0] mask;
    mask = (width >= MAX_W) ? '1 : ((64'd1 << width) - 64'd1);
    r    = '0;
    for (int i = 0; i < k; i++) r[i] = (i == 0) ? 1'b1 : (a[i] | b[i]);
    hi = {1'b0, (a & mask) >> k} + {1'b0, (b & mask) >> k};
    r  = r | (hi << k);
    return r;
  endfunction

  function automatic int seg_lo(input int width, input int k, input int stages, input int s);
    int u, base, rem;
    u    = width - k;
    base = u / stages;
    rem  = u % stages;
    return k + s * base + ((s < rem) ? s : rem);
  endfunction

  // Returns seg_lo-1 for an empty segment (only possible when K == WIDTH).
  function automatic int seg_hi(input int width, input int k, input int stages, input int s);
    int u, base, rem;
    u    = width - k;
    base = u / stages;
    rem  = u % stages;
    return seg_lo(width, k, stages, s) + base + ((s < rem) ? 1 : 0) - 1;
  endfunction

  function automatic bit params_ok(input int width, input int k, input int stages,
                                   input int acc_w);
    int max_st;
    max_st = (k == width) ? 1 : width - k;
    return (width >= 1) && (width <= MAX_W) && (k >= 0) && (k <= width) &&
           (stages >= 1) && (stages <= max_st) && (acc_w >= width + 1);
  endfunction

endpackage

// File: rtl/approx_add_seg.sv
// One pipeline stage of the approximate adder: ripple-adds operand bits [LO +: LEN]
// onto the carry registered by the previous stage and registers the result together
// with the operands, the partial sum and the exact reference sum.
//  clk, rst_n        clock, asynchronous active-low reset
//  load              stage may capture this cycle (empty, or its contents move on)
//  up_valid          previous stage / input holds a valid item
//  a_in, b_in        operands riding along the pipe
//  sum_in, carry_in  partial sum and carry from the previous stage
//  exact_in          exact a+b (all zero when the error monitor is compiled out)
//  *_out             registered versions of the above; valid_out is the stage-full flag
module approx_add_seg #(
  parameter int WIDTH = 8,
  parameter int LO    = 3,
  parameter int LEN   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] sum_in,
  input  logic             carry_in,
  input  logic [WIDTH:0]   exact_in,
  output logic             valid_out,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic [WIDTH:0]   exact_out
);

  logic             valid_q, valid_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [WIDTH:0]   exact_q, exact_d;
  logic [WIDTH-1:0] seg_sum;
  logic             c;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves one
    // unassigned and no latch is inferred.
    valid_d = valid_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    exact_d = exact_q;
    seg_sum = sum_in;
    // NOTE: blocking assignments here let c ripple bit by bit within one evaluation.
    c       = carry_in;
    for (int i = 0; i < WIDTH; i++) begin
      if (i >= LO && i < LO + LEN) begin
        seg_sum[i] = a_in[i] ^ b_in[i] ^ c;
        c          = (a_in[i] & b_in[i]) | (c & (a_in[i] ^ b_in[i]));
      end
    end
    if (load) begin
      valid_d = up_valid;
      // Data only changes when a real item arrives, so outputs stay stable when idle.
      if (up_valid) begin
        a_d     = a_in;
        b_d     = b_in;
        sum_d   = seg_sum;
        carry_d = c;
        exact_d = exact_in;
      end
    end
  end

  // NOTE: datapath registers are reset too, because the last stage drives sum,
  // which must read zero while reset is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      exact_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every stage samples pre-edge values.
      valid_q <= valid_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      exact_q <= exact_d;
    end
  end

  assign valid_out = valid_q;
  assign carry_out = carry_q;
  assign a_out     = a_q;
  assign b_out     = b_q;
  assign sum_out   = sum_q;
  assign exact_out = exact_q;

endmodule

// File: rtl/approx_add_pipe.sv
// Pipelined unsigned approximate adder (lower-part OR) with valid/ready handshake.
// The low APPROX_LSB bits are approximated (bit 0 forced to 1, others a|b, no carry out);
// the upper part is added exactly, split over STAGES register stages.
// Optional error monitor enabled by defining APPROX_ADD_ERR_MON_EN; otherwise
// err_sum/err_max/err_cnt/smp_cnt read zero and err_clr is ignored.
//  clk, rst_n            clock, asynchronous active-low reset
//  in_valid/in_ready, a, b     operand handshake
//  out_valid/out_ready, sum    result handshake, sum is WIDTH+1 bits
//  err_clr                     synchronous clear of the monitor
//  err_sum, err_max, err_cnt, smp_cnt   saturating monitor outputs
module approx_add_pipe
  import approx_add_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int APPROX_LSB = 3,
  parameter int STAGES     = 2,
  parameter int ERR_ACC_W  = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH:0]       sum,
  input  logic                 err_clr,
  output logic [ERR_ACC_W-1:0] err_sum,
  output logic [WIDTH:0]       err_max,
  output logic [ERR_ACC_W-1:0] err_cnt,
  output logic [ERR_ACC_W-1:0] smp_cnt
);

  localparam int K = APPROX_LSB;

  if (!params_ok(WIDTH, APPROX_LSB, STAGES, ERR_ACC_W)) begin : g_bad_params
    $error("approx_add_pipe: illegal WIDTH/APPROX_LSB/STAGES/ERR_ACC_W combination");
  end

  // Index s is the input of stage s; index STAGES is the pipeline output.
  logic             valid_pipe [0:STAGES];
  logic             carry_pipe [0:STAGES];
  logic [WIDTH-1:0] a_pipe     [0:STAGES];
  logic [WIDTH-1:0] b_pipe     [0:STAGES];
  logic [WIDTH-1:0] sum_pipe   [0:STAGES];
  logic [WIDTH:0]   exact_pipe [0:STAGES];
  logic [STAGES:0]  ready;
  logic [WIDTH-1:0] low_sum;

  always_comb begin
    low_sum = '0;
    for (int i = 0; i < K; i++) low_sum[i] = (i == 0) ? 1'b1 : (a[i] | b[i]);
  end

  assign valid_pipe[0] = in_valid;
  assign carry_pipe[0] = 1'b0;
  assign a_pipe[0]     = a;
  assign b_pipe[0]     = b;
  assign sum_pipe[0]   = low_sum;
`ifdef APPROX_ADD_ERR_MON_EN
  assign exact_pipe[0] = {1'b0, a} + {1'b0, b};
`else
  // Constant zero: the exact-sum registers in every stage trim away.
  assign exact_pipe[0] = '0;
`endif

  // A stage can take a new item if it is empty or everything downstream moves this
  // cycle; out_ready ripples back through the whole pipe so no bubble is needed.
  always_comb begin
    ready         = '0;
    ready[STAGES] = out_ready;
    for (int s = STAGES - 1; s >= 0; s--) ready[s] = !valid_pipe[s+1] | ready[s+1];
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int LO = seg_lo(WIDTH, K, STAGES, s);
    localparam int HI = seg_hi(WIDTH, K, STAGES, s);
    approx_add_seg #(
      .WIDTH(WIDTH),
      .LO   (LO),
      .LEN  (HI - LO + 1)
    ) u_seg (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (ready[s]),
      .up_valid (valid_pipe[s]),
      .a_in     (a_pipe[s]),
      .b_in     (b_pipe[s]),
      .sum_in   (sum_pipe[s]),
      .carry_in (carry_pipe[s]),
      .exact_in (exact_pipe[s]),
      .valid_out(valid_pipe[s+1]),
      .a_out    (a_pipe[s+1]),
      .b_out    (b_pipe[s+1]),
      .sum_out  (sum_pipe[s+1]),
      .carry_out(carry_pipe[s+1]),
      .exact_out(exact_pipe[s+1])
    );
  end

  // Gated with rst_n so nothing is offered as accepted while reset is held.
  assign in_ready  = rst_n & ready[0];
  assign out_valid = valid_pipe[STAGES];
  assign sum       = {carry_pipe[STAGES], sum_pipe[STAGES]};

`ifdef APPROX_ADD_ERR_MON_EN
  localparam int ACC_W1 = ERR_ACC_W + 1;

  logic [ERR_ACC_W-1:0] err_sum_q, err_sum_d, err_cnt_q, err_cnt_d, smp_cnt_q, smp_cnt_d;
  logic [WIDTH:0]       err_max_q, err_max_d;
  logic [WIDTH:0]       diff;
  logic [ACC_W1-1:0]    sum_ext;
  logic                 xfer;

  assign xfer = out_valid & out_ready;

  always_comb begin
    diff      = (exact_pipe[STAGES] >= sum) ? exact_pipe[STAGES] - sum
                                            : sum - exact_pipe[STAGES];
    // Clearing first means a transfer in the clear cycle is the only thing counted.
    err_sum_d = err_clr ? '0 : err_sum_q;
    err_max_d = err_clr ? '0 : err_max_q;
    err_cnt_d = err_clr ? '0 : err_cnt_q;
    smp_cnt_d = err_clr ? '0 : smp_cnt_q;
    sum_ext   = '0;
    if (xfer) begin
      sum_ext   = {1'b0, err_sum_d} + ACC_W1'(diff);
      err_sum_d = sum_ext[ERR_ACC_W] ? '1 : sum_ext[ERR_ACC_W-1:0];
      if (diff > err_max_d) err_max_d = diff;
      if ((|diff) && (err_cnt_d != '1)) err_cnt_d = err_cnt_d + ERR_ACC_W'(1);
      if (smp_cnt_d != '1) smp_cnt_d = smp_cnt_d + ERR_ACC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sum_q <= '0;
      err_max_q <= '0;
      err_cnt_q <= '0;
      smp_cnt_q <= '0;
    end else begin
      err_sum_q <= err_sum_d;
      err_max_q <= err_max_d;
      err_cnt_q <= err_cnt_d;
      smp_cnt_q <= smp_cnt_d;
    end
  end

  assign err_sum = err_sum_q;
  assign err_max = err_max_q;
  assign err_cnt = err_cnt_q;
  assign smp_cnt = smp_cnt_q;
`else
  assign err_sum = '0;
  assign err_max = '0;
  assign err_cnt = '0;
  assign smp_cnt = '0;
`endif

endmodule

// File: tb/tb_approx_add_pipe.sv
// Directed bench for approx_add_pipe (WIDTH=8, K=3, STAGES=2, ERR_ACC_W=24).
// Monitor expectations follow APPROX_ADD_ERR_MON_EN: hand values when defined, zero otherwise.
module tb_approx_add_pipe;

  localparam int WIDTH = 8;
`ifdef APPROX_ADD_ERR_MON_EN
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;
  logic             err_clr;
  logic [23:0]      err_sum;
  logic [WIDTH:0]   err_max;
  logic [23:0]      err_cnt;
  logic [23:0]      smp_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Stream vectors and their hand-computed approximate sums.
  logic [7:0] va [6] = '{8'h10, 8'h0A, 8'h80, 8'h3C, 8'hF0, 8'h55};
  logic [7:0] vb [6] = '{8'h20, 8'h05, 8'h80, 8'h42, 8'h0F, 8'hAA};
  logic [8:0] vs [6] = '{9'h031, 9'h00F, 9'h101, 9'h07F, 9'h0FF, 9'h0FF};

  approx_add_pipe #(
    .WIDTH     (WIDTH),
    .APPROX_LSB(3),
    .STAGES    (2),
    .ERR_ACC_W (24)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .err_clr  (err_clr),
    .err_sum  (err_sum),
    .err_max  (err_max),
    .err_cnt  (err_cnt),
    .smp_cnt  (smp_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_mon(input string tag, input int es, input int em, input int ec,
                           input int esm);
    check({tag, "_err_sum"}, 32'(err_sum), MON ? 32'(es)  : 32'd0);
    check({tag, "_err_max"}, 32'(err_max), MON ? 32'(em)  : 32'd0);
    check({tag, "_err_cnt"}, 32'(err_cnt), MON ? 32'(ec)  : 32'd0);
    check({tag, "_smp_cnt"}, 32'(smp_cnt), MON ? 32'(esm) : 32'd0);
  endtask

  // Offers one pair on an empty pipe with out_ready high; the result must appear
  // exactly two cycles after the accept cycle. Returns at the negedge where it is shown.
  task automatic send_one(input logic [7:0] ta, input logic [7:0] tb_, input logic [8:0] es,
                          input string tag);
    @(negedge clk);
    in_valid = 1'b1;
    a        = ta;
    b        = tb_;
    #1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_lat1_out_valid"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_lat2_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_sum"}, 32'(sum), 32'(es));
  endtask

  initial begin
    int tx, rx, last_rx;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    err_clr   = 1'b0;
    a         = '0;
    b         = '0;

    // Reset state.
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check_mon("rst", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Single vectors: 0+0 (d=1), 7+1 (d=1), FF+FF (d=7, worst case).
    send_one(8'h00, 8'h00, 9'h001, "v00");
    send_one(8'h07, 8'h01, 9'h007, "v07");
    send_one(8'hFF, 8'hFF, 9'h1F7, "vff");
    @(negedge clk);
    check("drain_out_valid", 32'(out_valid), 32'd0);
    check_mon("three", 9, 7, 3, 3);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check_mon("clr", 0, 0, 0, 0);

    // Stream of 6 pairs, out_ready held low for cycles 0..4.
    tx      = 0;
    rx      = 0;
    last_rx = -1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      out_ready = (c >= 5);
      in_valid  = (tx < 6);
      if (tx < 6) begin
        a = va[tx];
        b = vb[tx];
      end
      #1;
      if (c >= 2 && c <= 4) check($sformatf("stall_in_ready_c%0d", c), 32'(in_ready), 32'd0);
      if (out_valid) begin
        if (rx < 6) check($sformatf("stream_sum_c%0d", c), 32'(sum), 32'(vs[rx]));
        if (out_ready) begin
          rx++;
          last_rx = c;
        end
      end
      if (in_valid && in_ready) tx++;
    end
    in_valid = 1'b0;
    check("stream_rx_count", 32'(rx), 32'd6);
    check("stream_last_cycle", 32'(last_rx), 32'd10);
    check_mon("stream", 3, 1, 3, 6);

    // Clear in the same cycle as a transfer keeps only that transfer.
    send_one(8'h00, 8'h00, 9'h001, "clrx");
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check_mon("clr_xfer", 1, 1, 1, 1);

    // Reset asserted with two items held in the pipe.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a         = 8'h11;
    b         = 8'h22;
    @(negedge clk);
    a = 8'h33;
    b = 8'h44;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sum", 32'(sum), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check_mon("mid_rst", 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("rel_no_stale_c%0d", c), 32'(out_valid), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
